// File: rtl/i2c_host_bridge.sv
// rtl/i2c_host_bridge.sv - register-mapped host front end with TX/RX FIFOs for the I2C master
module i2c_host_bridge #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sel,
    input  logic       wr,
    input  logic [2:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ready,
    output logic [7:0] ctrl_o,
    output logic [7:0] saddr_o,
    output logic [7:0] count_o,
    output logic [7:0] data_in_o,
    output logic       din_write_o,
    output logic       dout_read_o,
    input  logic [7:0] status_i,
    input  logic [7:0] data_out_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic {TX_IDLE, TX_WAIT} tx_state_t;
    typedef enum logic {RX_IDLE, RX_WAIT} rx_state_t;

    logic [7:0] r_ctrl, r_saddr, r_count, r_rdata;
    logic       r_ready, r_din_write, r_dout_read;
    logic       r_tx_ovf, r_rx_ovf;
    logic [7:0] r_tx_mem [FIFO_DEPTH];
    logic [7:0] r_rx_mem [FIFO_DEPTH];
    logic [AW:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    tx_state_t  r_tx_state, w_tx_next;
    rx_state_t  r_rx_state, w_rx_next;

    logic       w_cap, w_wr_acc, w_rd_acc;
    logic       w_xrdy, w_rrdy;
    logic       w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic       w_tx_flush, w_rx_flush, w_clr_ovf;
    logic       w_tx_push_req, w_tx_push, w_tx_drop, w_tx_pop;
    logic       w_rx_take, w_rx_push, w_rx_drop, w_rx_pop;
    logic [7:0] w_fifostat, w_rd_val;

    // An access is taken once: ready blocks recapture on the following edge
    assign w_cap    = sel & ~r_ready;
    assign w_wr_acc = w_cap & wr;
    assign w_rd_acc = w_cap & ~wr;

    assign w_xrdy = status_i[2];
    assign w_rrdy = status_i[3];

    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]) && (r_tx_wp[AW] != r_tx_rp[AW]);
    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]) && (r_rx_wp[AW] != r_rx_rp[AW]);

    assign w_tx_flush = w_wr_acc && (addr == 3'd6) && wdata[0];
    assign w_rx_flush = w_wr_acc && (addr == 3'd6) && wdata[1];
    assign w_clr_ovf  = w_wr_acc && (addr == 3'd6) && wdata[7];

    // A same-cycle pop frees the slot a push into a full FIFO needs
    assign w_tx_push_req = w_wr_acc && (addr == 3'd3);
    assign w_tx_push     = w_tx_push_req && (!w_tx_full || w_tx_pop);
    assign w_tx_drop     = w_tx_push_req && w_tx_full && !w_tx_pop;

    assign w_rx_pop  = w_rd_acc && (addr == 3'd4) && !w_rx_empty;
    assign w_rx_push = w_rx_take && !w_rx_flush && (!w_rx_full || w_rx_pop);
    assign w_rx_drop = w_rx_take && !w_rx_flush && w_rx_full && !w_rx_pop;

    assign w_fifostat = {r_rx_ovf, r_tx_ovf, 2'b00, w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};

    // Read data mux for the register map
    always_comb begin
        w_rd_val = 8'h00;
        case (addr)
            3'd0:    w_rd_val = r_ctrl;
            3'd1:    w_rd_val = r_saddr;
            3'd2:    w_rd_val = r_count;
            3'd4:    w_rd_val = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp[AW-1:0]];
            3'd5:    w_rd_val = status_i;
            3'd6:    w_rd_val = w_fifostat;
            default: w_rd_val = 8'h00;
        endcase
    end

    // Control registers, access-complete pulse and registered read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl  <= 8'h00;
            r_saddr <= 8'h00;
            r_count <= 8'h00;
            r_rdata <= 8'h00;
            r_ready <= 1'b0;
        end else begin
            r_ready <= w_cap;
            if (w_rd_acc) r_rdata <= w_rd_val;
            if (w_wr_acc) begin
                if (addr == 3'd0) r_ctrl  <= wdata;
                if (addr == 3'd1) r_saddr <= wdata;
                if (addr == 3'd2) r_count <= wdata;
            end
        end
    end

    // TX FIFO pointers; flush wins over any same-cycle push or pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
        end else if (w_tx_flush) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + PTR_ONE;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + PTR_ONE;
        end
    end

    // RX FIFO pointers; flush wins over any same-cycle push or pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else if (w_rx_flush) begin
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + PTR_ONE;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + PTR_ONE;
        end
    end

    // FIFO storage needs no reset: pointers alone define validity
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= wdata;
        if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= data_out_i;
    end

    // Sticky overflow flags; a new overflow outranks a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_ovf <= 1'b0;
            r_rx_ovf <= 1'b0;
        end else begin
            if (w_clr_ovf) begin
                r_tx_ovf <= 1'b0;
                r_rx_ovf <= 1'b0;
            end
            if (w_tx_drop) r_tx_ovf <= 1'b1;
            if (w_rx_drop) r_rx_ovf <= 1'b1;
        end
    end

    // Feeder and drainer state plus their registered master strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state  <= TX_IDLE;
            r_rx_state  <= RX_IDLE;
            r_din_write <= 1'b0;
            r_dout_read <= 1'b0;
        end else begin
            r_tx_state  <= w_tx_next;
            r_rx_state  <= w_rx_next;
            r_din_write <= w_tx_pop;
            r_dout_read <= w_rx_take;
        end
    end

    // TX feeder: one byte per xrdy assertion, only when data is queued
    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_pop  = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (w_xrdy && !w_tx_empty && !w_tx_flush) begin
                    w_tx_pop  = 1'b1;
                    w_tx_next = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (!w_xrdy) w_tx_next = TX_IDLE;
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    // RX drainer: acknowledge every rrdy assertion once, even if the byte is dropped
    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_take = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_rrdy) begin
                    w_rx_take = 1'b1;
                    w_rx_next = RX_WAIT;
                end
            end
            RX_WAIT: begin
                if (!w_rrdy) w_rx_next = RX_IDLE;
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    assign rdata       = r_rdata;
    assign ready       = r_ready;
    assign ctrl_o      = r_ctrl;
    assign saddr_o     = r_saddr;
    assign count_o     = r_count;
    assign data_in_o   = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rp[AW-1:0]];
    assign din_write_o = r_din_write;
    assign dout_read_o = r_dout_read;

endmodule

// File: tb/tb_i2c_host_bridge.sv
// tb/tb_i2c_host_bridge.sv - self-checking bench for i2c_host_bridge
module tb_i2c_host_bridge;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sel = 1'b0, wr = 1'b0;
    logic [2:0] addr = 3'd0;
    logic [7:0] wdata = 8'h00, status_i = 8'h00, data_out_i = 8'h00;
    logic [7:0] rdata, ctrl_o, saddr_o, count_o, data_in_o;
    logic       ready, din_write_o, dout_read_o;

    int n_cmp = 0;
    int n_fail = 0;
    int din_cnt = 0;
    int dout_cnt = 0;
    bit run_cmp = 1'b0;

    i2c_host_bridge #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .sel(sel), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .ctrl_o(ctrl_o), .saddr_o(saddr_o), .count_o(count_o),
        .data_in_o(data_in_o), .din_write_o(din_write_o), .dout_read_o(dout_read_o),
        .status_i(status_i), .data_out_i(data_out_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: queues for the FIFOs, one strobe per ready-line assertion
    logic [7:0] m_ctrl = 0, m_saddr = 0, m_count = 0, m_rdata = 0;
    bit m_ready = 0, m_din = 0, m_dout = 0, m_tx_arm = 1, m_rx_arm = 1, m_tx_ovf = 0, m_rx_ovf = 0;
    byte unsigned m_txq[$];
    byte unsigned m_rxq[$];

    always @(posedge clk or negedge reset) begin
        bit cap, txf, rxf, pop_tx, take_rx;
        if (!reset) begin
            m_ctrl = 0; m_saddr = 0; m_count = 0; m_rdata = 0;
            m_ready = 0; m_din = 0; m_dout = 0; m_tx_arm = 1; m_rx_arm = 1;
            m_tx_ovf = 0; m_rx_ovf = 0;
            m_txq.delete(); m_rxq.delete();
        end else begin
            cap     = sel && !m_ready;
            txf     = cap && wr && addr == 3'd6 && wdata[0];
            rxf     = cap && wr && addr == 3'd6 && wdata[1];
            pop_tx  = status_i[2] && m_tx_arm && m_txq.size() > 0 && !txf;
            take_rx = status_i[3] && m_rx_arm;
            if (cap && !wr) begin
                case (addr)
                    3'd0: m_rdata = m_ctrl;
                    3'd1: m_rdata = m_saddr;
                    3'd2: m_rdata = m_count;
                    3'd4: begin
                        if (m_rxq.size() > 0) m_rdata = m_rxq.pop_front();
                        else m_rdata = 8'h00;
                    end
                    3'd5: m_rdata = status_i;
                    3'd6: m_rdata = {m_rx_ovf, m_tx_ovf, 2'b00, m_rxq.size() == DEPTH, m_rxq.size() == 0,
                                     m_txq.size() == DEPTH, m_txq.size() == 0};
                    default: m_rdata = 8'h00;
                endcase
            end
            if (pop_tx) void'(m_txq.pop_front());
            if (cap && wr) begin
                case (addr)
                    3'd0: m_ctrl = wdata;
                    3'd1: m_saddr = wdata;
                    3'd2: m_count = wdata;
                    3'd3: begin
                        if (m_txq.size() < DEPTH) m_txq.push_back(wdata);
                        else m_tx_ovf = 1;
                    end
                    3'd6: begin
                        if (wdata[7]) begin m_tx_ovf = 0; m_rx_ovf = 0; end
                        if (txf) m_txq.delete();
                        if (rxf) m_rxq.delete();
                    end
                    default: ;
                endcase
            end
            if (take_rx && !rxf) begin
                if (m_rxq.size() < DEPTH) m_rxq.push_back(data_out_i);
                else m_rx_ovf = 1;
            end
            if (pop_tx) m_tx_arm = 0;
            else if (!status_i[2]) m_tx_arm = 1;
            if (take_rx) m_rx_arm = 0;
            else if (!status_i[3]) m_rx_arm = 1;
            m_din   = pop_tx;
            m_dout  = take_rx;
            m_ready = cap;
        end
    end

    // Compare every output against the model once per cycle, away from the active edge
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("ready", {7'd0, ready}, {7'd0, m_ready});
            chk("rdata", rdata, m_rdata);
            chk("ctrl_o", ctrl_o, m_ctrl);
            chk("saddr_o", saddr_o, m_saddr);
            chk("count_o", count_o, m_count);
            chk("data_in_o", data_in_o, (m_txq.size() > 0) ? m_txq[0] : 8'h00);
            chk("din_write_o", {7'd0, din_write_o}, {7'd0, m_din});
            chk("dout_read_o", {7'd0, dout_read_o}, {7'd0, m_dout});
        end
        if (din_write_o) din_cnt++;
        if (dout_read_o) dout_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(output logic [7:0] d);
        int k;
        k = 0;
        d = 8'h00;
        while (k < 8) begin
            @(negedge clk);
            if (ready) break;
            k++;
        end
        if (k == 8) begin
            n_cmp++;
            n_fail++;
            $display("FAIL bus_timeout: got no ready expected ready within 8 cycles");
        end else begin
            d = rdata;
        end
        @(posedge clk);
        #2;
        sel = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
        wait_ready(dummy);
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        sel = 1'b1; wr = 1'b0; addr = a;
        wait_ready(d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic [7:0] exp_rd [8];
        int snap;
        exp_rd = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h30, 8'h05, 8'h00};

        tick(3);
        run_cmp = 1'b1;
        chk("rst_ready", {7'd0, ready}, 8'h00);
        chk("rst_data_in", data_in_o, 8'h00);
        reset = 1'b1;
        status_i = 8'h30;
        tick(1);

        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), d);
            chk($sformatf("rd_reset_addr%0d", i), d, exp_rd[i]);
        end

        bus_write(3'd1, 8'h50);
        bus_write(3'd2, 8'h02);
        bus_write(3'd0, 8'h03);
        chk("saddr_o_lit", saddr_o, 8'h50);
        chk("count_o_lit", count_o, 8'h02);
        chk("ctrl_o_lit", ctrl_o, 8'h03);
        bus_read(3'd1, d); chk("rd_saddr", d, 8'h50);
        bus_read(3'd2, d); chk("rd_count", d, 8'h02);
        bus_read(3'd0, d); chk("rd_ctrl", d, 8'h03);
        status_i = 8'h00;

        bus_write(3'd3, 8'hA5);
        chk("head_a5", data_in_o, 8'hA5);
        bus_write(3'd3, 8'h3C);
        chk("head_still_a5", data_in_o, 8'hA5);
        snap = din_cnt;
        status_i = 8'h04; tick(1);
        status_i = 8'h00; tick(3);
        chk("head_3c", data_in_o, 8'h3C);
        status_i = 8'h04; tick(3);
        status_i = 8'h00; tick(2);
        chk("din_pulses", 8'(din_cnt - snap), 8'd2);
        bus_read(3'd6, d); chk("fifostat_tx_drained", d, 8'h05);

        for (int b = 1; b <= 5; b++) bus_write(3'd3, 8'(b));
        bus_read(3'd6, d); chk("fifostat_tx_ovf", d, 8'h46);
        chk("head_after_ovf", data_in_o, 8'h01);
        bus_write(3'd6, 8'h81);
        bus_read(3'd6, d); chk("fifostat_after_flush", d, 8'h05);

        snap = dout_cnt;
        for (int b = 8'h11; b <= 8'h15; b++) begin
            data_out_i = 8'(b);
            status_i = 8'h08; tick(1);
            status_i = 8'h00; tick(1);
        end
        chk("dout_pulses", 8'(dout_cnt - snap), 8'd5);
        bus_read(3'd6, d); chk("fifostat_rx_ovf", d, 8'h89);
        for (int i = 0; i < 4; i++) begin
            bus_read(3'd4, d);
            chk($sformatf("rx_byte%0d", i), d, 8'(8'h11 + i));
        end
        bus_read(3'd4, d); chk("rx_empty_read", d, 8'h00);
        bus_read(3'd6, d); chk("fifostat_rx_sticky", d, 8'h85);
        bus_write(3'd6, 8'h80);
        bus_read(3'd6, d); chk("fifostat_cleared", d, 8'h05);

        data_out_i = 8'h21; status_i = 8'h08; tick(1); status_i = 8'h00; tick(1);
        data_out_i = 8'h22; status_i = 8'h08; tick(1); status_i = 8'h00; tick(1);
        bus_write(3'd6, 8'h02);
        bus_read(3'd6, d); chk("fifostat_rx_flush", d, 8'h05);

        bus_write(3'd3, 8'hDE);
        bus_write(3'd3, 8'hAD);
        bus_write(3'd3, 8'hBE);
        status_i = 8'h04; tick(2);
        chk("head_before_reset", data_in_o, 8'hAD);
        reset = 1'b0;
        #1;
        chk("rst_mid_ctrl", ctrl_o, 8'h00);
        chk("rst_mid_saddr", saddr_o, 8'h00);
        chk("rst_mid_data_in", data_in_o, 8'h00);
        chk("rst_mid_rdata", rdata, 8'h00);
        chk("rst_mid_din", {7'd0, din_write_o}, 8'h00);
        tick(2);
        snap = din_cnt;
        reset = 1'b1;
        tick(5);
        chk("no_din_when_empty", 8'(din_cnt - snap), 8'd0);
        status_i = 8'h00;
        bus_read(3'd6, d); chk("fifostat_after_reset", d, 8'h05);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
